mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences the accesses. MEM stage has priority because it holds the older instruction.
- Drives a global stall that freezes PC, IFID and the downstream pipes until every pending access of the current cycle is complete.

---
 rtl/mem_port_arbiter_pkg.sv | 6 +
 rtl/mem_port_arbiter_if.sv | 11 +
 rtl/mem_port_fetch_buf.sv | 24 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding and constants for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RELEASE} state_t;
  localparam int TMO_W = 8;
  localparam logic ERR_NONE = 1'b0;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: single-port memory bus, master side driven by the arbiter
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic m_req;
  logic m_we;
  logic m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  modport master(output m_req, m_we, m_addr, m_wdata, input m_rdata, m_ack);
  modport slave(input m_req, m_we, m_addr, m_wdata, output m_rdata, m_ack);
endinterface

// File: rtl/mem_port_fetch_buf.sv
// mem_port_fetch_buf: one-entry buffer holding the last fetched word and its address
module mem_port_fetch_buf #(parameter int AW = 32, parameter int DW = 32) (
  input  logic clk,
  input  logic rst,
  input  logic fill,
  input  logic inv,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic [AW-1:0] look_addr,
  output logic hit,
  output logic [DW-1:0] data
);
  logic valid;
  logic [AW-1:0] tag;
  always_ff @(posedge clk)
    if (rst) valid <= 1'b0;
    else valid <= fill ? 1'b1 : inv ? 1'b0 : valid;
  always_ff @(posedge clk)
    if (fill) begin
      tag <= fill_addr;
      data <= fill_data;
    end
  assign hit = valid && tag == look_addr;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences MEM-stage then IF-stage accesses on one memory port and stalls the pipeline; MEM_PORT_IBUF_EN adds a fetch buffer
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(parameter int AW = 32, parameter int DW = 32, parameter int TMO = 255) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  input  logic d_rd,
  input  logic d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic stall,
  output logic err,
  mem_port_arbiter_if.master mem
);
  state_t state, state_d;
  logic d_done, i_done, d_done_d, i_done_d;
  logic [TMO_W-1:0] cnt, cnt_d;
  logic req_d, we_d, err_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d, if_rdata_d, d_rdata_d, rdata, buf_data;
  logic d_op, acc, tmo, fin, hit;
  assign d_op = d_rd | d_wr;
  assign stall = state != RELEASE && (d_op && !d_done || if_req && !i_done);
  assign acc = state == D_ACC || state == I_ACC;
  assign tmo = acc && !mem.m_ack && cnt == TMO_W'(TMO - 1);
  assign fin = acc && (mem.m_ack || tmo);
  assign rdata = mem.m_ack ? mem.m_rdata : '0;
`ifdef MEM_PORT_IBUF_EN
  logic buf_hit;
  mem_port_fetch_buf #(.AW(AW), .DW(DW)) u_fetch_buf (
    .clk(clk),
    .rst(rst),
    .fill(state == I_ACC && mem.m_ack),
    .inv(d_wr && state == IDLE),
    .fill_addr(mem.m_addr),
    .fill_data(mem.m_rdata),
    .look_addr(if_addr),
    .hit(buf_hit),
    .data(buf_data)
  );
  assign hit = buf_hit && if_req && !d_wr;
`else
  assign hit = 1'b0;
  assign buf_data = '0;
`endif
  always_comb begin
    state_d = state;
    req_d = mem.m_req;
    we_d = mem.m_we;
    addr_d = mem.m_addr;
    wdata_d = mem.m_wdata;
    d_done_d = d_done;
    i_done_d = i_done;
    cnt_d = acc ? cnt + 1'b1 : '0;
    if_rdata_d = if_rdata;
    d_rdata_d = d_rdata;
    err_d = err | tmo;
    case (state)
      IDLE: begin
        i_done_d = hit;
        if_rdata_d = hit ? buf_data : if_rdata;
        if (d_op) begin
          state_d = D_ACC;
          req_d = 1'b1;
          we_d = d_wr;
          addr_d = d_addr;
          wdata_d = d_wdata;
        end else if (hit) state_d = RELEASE;
        else if (if_req) begin
          state_d = I_ACC;
          req_d = 1'b1;
          we_d = 1'b0;
          addr_d = if_addr;
        end
      end
      D_ACC: if (fin) begin
        d_done_d = 1'b1;
        cnt_d = '0;
        d_rdata_d = d_rd ? rdata : d_rdata;
        if (if_req && !i_done) begin
          state_d = I_ACC;
          we_d = 1'b0;
          addr_d = if_addr;
        end else begin
          state_d = RELEASE;
          req_d = 1'b0;
        end
      end
      I_ACC: if (fin) begin
        i_done_d = 1'b1;
        cnt_d = '0;
        if_rdata_d = rdata;
        req_d = 1'b0;
        state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
        d_done_d = 1'b0;
        i_done_d = 1'b0;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      mem.m_req <= 1'b0;
      mem.m_we <= 1'b0;
      mem.m_addr <= '0;
      mem.m_wdata <= '0;
      d_done <= 1'b0;
      i_done <= 1'b0;
      cnt <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      err <= ERR_NONE;
    end else begin
      state <= state_d;
      mem.m_req <= req_d;
      mem.m_we <= we_d;
      mem.m_addr <= addr_d;
      mem.m_wdata <= wdata_d;
      d_done <= d_done_d;
      i_done <= i_done_d;
      cnt <= cnt_d;
      if_rdata <= if_rdata_d;
      d_rdata <= d_rdata_d;
      err <= err_d;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a latency-programmable memory model and a transaction-level reference
module tb_mem_port_arbiter;
  localparam int TMO = 6;
  localparam logic [31:0] STRAY = 32'h1234_5678;
  typedef struct {int cyc; logic [31:0] d; logic [31:0] i; logic e;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] wd; logic we; int lat;} acc_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata;
  logic stall, err;
  logic mem_ack = 1'b0, stray_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  int tests = 0, fails = 0;
  bit running = 0;
  exp_t exp_q[$];
  acc_t acc_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] exp_d = '0, exp_i = '0;
  logic err_m = 1'b0;
  mem_port_arbiter_if #(.AW(32), .DW(32)) mb();
  assign mb.m_ack = mem_ack | stray_ack;
  assign mb.m_rdata = stray_ack ? STRAY : mem_rdata;
  mem_port_arbiter #(.AW(32), .DW(32), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .stall(stall), .err(err), .mem(mb)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] dflt(logic [31:0] a);
    return a * 32'h9E37_79B1 ^ 32'h5A5A_5A5A;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask
  // memory model: each access acks after its programmed latency; gives up after TMO cycles like the arbiter
  int w = 0;
  bit busy = 0;
  acc_t cur;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst || !mb.m_req) busy = 0;
    else begin
      if (!busy) begin
        busy = 1;
        w = 0;
        if (acc_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL acc_order: unexpected access addr %h", mb.m_addr);
          cur.lat = 0;
        end else begin
          cur = acc_q.pop_front();
          chk("m_addr", mb.m_addr, cur.a);
          chk("m_we", {31'b0, mb.m_we}, {31'b0, cur.we});
          if (cur.we) chk("m_wdata", mb.m_wdata, cur.wd);
        end
      end
      if (w == cur.lat) begin
        mem_ack = 1'b1;
        if (mb.m_we) mem[mb.m_addr] = mb.m_wdata;
        else mem_rdata = mem.exists(mb.m_addr) ? mem[mb.m_addr] : dflt(mb.m_addr);
        busy = 0;
      end else if (w == TMO - 1) busy = 0;
      else w++;
    end
  end
  // monitor: every stall-free cycle retires one transaction
  int scnt = 0;
  always @(negedge clk) begin
    if (running) begin
      if (stall) scnt++;
      else if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL retire: no expected transaction");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stall_cycles", scnt, e.cyc);
        chk("d_rdata", d_rdata, e.d);
        chk("if_rdata", if_rdata, e.i);
        chk("err", {31'b0, err}, {31'b0, e.e});
        scnt = 0;
      end
    end
  end
  task automatic run_txn(int op, logic [31:0] da, logic [31:0] wd, logic fq, logic [31:0] ia, int ld, int li);
    exp_t e;
    acc_t x;
    bit to, ok;
    d_rd = op == 1;
    d_wr = op == 2;
    d_addr = da;
    d_wdata = wd;
    if_req = fq;
    if_addr = ia;
    e.cyc = (op != 0 || fq) ? 1 : 0;
    if (op != 0) begin
      x.a = da; x.wd = wd; x.we = op == 2; x.lat = ld;
      acc_q.push_back(x);
      to = ld >= TMO;
      e.cyc += to ? TMO : ld + 1;
      err_m |= to;
      if (op == 1) exp_d = to ? '0 : ref_mem.exists(da) ? ref_mem[da] : dflt(da);
      else if (!to) ref_mem[da] = wd;
    end
    if (fq) begin
      x.a = ia; x.wd = '0; x.we = 1'b0; x.lat = li;
      acc_q.push_back(x);
      to = li >= TMO;
      e.cyc += to ? TMO : li + 1;
      err_m |= to;
      exp_i = to ? '0 : ref_mem.exists(ia) ? ref_mem[ia] : dflt(ia);
    end
    e.d = exp_d;
    e.i = exp_i;
    e.e = err_m;
    exp_q.push_back(e);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = !stall;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL stall_bound: stall still high after 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_req", {31'b0, mb.m_req}, 32'd0);
    chk("rst_m_we", {31'b0, mb.m_we}, 32'd0);
    chk("rst_m_addr", mb.m_addr, 32'd0);
    chk("rst_m_wdata", mb.m_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    running = 1;
    run_txn(2, 32'h10, 32'h8C01_0004, 1'b0, 32'h0, 1, 0);
    run_txn(0, 32'h0, 32'h0, 1'b1, 32'h10, 0, 0);
    run_txn(1, 32'h200, 32'h0, 1'b1, 32'h14, 0, 0);
    run_txn(2, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 0);
    run_txn(1, 32'h40, 32'h0, 1'b0, 32'h0, 4, 0);
    run_txn(1, 32'h44, 32'h0, 1'b0, 32'h0, 100, 0);
    run_txn(0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      int op, ld, li;
      op = int'($urandom_range(0, 3)) % 3;
      ld = ($urandom_range(0, 9) == 0) ? TMO + 3 : int'($urandom_range(0, 3));
      li = ($urandom_range(0, 9) == 0) ? TMO + 3 : int'($urandom_range(0, 3));
      run_txn(op, {$urandom_range(0, 15), 2'b00}, $urandom, $urandom_range(0, 3) != 0,
              {$urandom_range(0, 15), 2'b00}, ld, li);
    end
    running = 0;
    if_req = 1'b1;
    if_addr = 32'h80;
    d_rd = 1'b0;
    d_wr = 1'b0;
    cur.lat = 0;
    acc_q.push_back('{a: 32'h80, wd: 32'h0, we: 1'b0, lat: 100});
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_m_req", {31'b0, mb.m_req}, 32'd1);
    rst = 1'b1;
    if_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_m_req", {31'b0, mb.m_req}, 32'd0);
    chk("mid_rst_d_rdata", d_rdata, 32'd0);
    chk("mid_rst_err", {31'b0, err}, 32'd0);
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_if_rdata", if_rdata, 32'd0);
    chk("stray_d_rdata", d_rdata, 32'd0);
    chk("stray_m_req", {31'b0, mb.m_req}, 32'd0);
    chk("stray_stall", {31'b0, stall}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
